pc_alu_branch_unit: RTL and testbench
=====================================

PC_ALU_BRANCH_UNIT -- requirements
Module: pc_alu_branch_unit

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter FILL_CYCLES, default 3, number of rising edges after reset release before can_write asserts.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc_src  input  1  1 = load jump_addr next edge; 0 = sequential fetch.
REQ-006 jump_addr  input  32  redirect target.
REQ-007 i_addr  output  32  current PC (registered).
REQ-008 can_write  output  1  pipeline-filled flag; gates register-file writes.
REQ-009 A, B  input  32 each  ALU operands.
REQ-010 alu_op  input  3  ALU operation select.
REQ-011 result  output  32  ALU result (combinational).
REQ-012 zero, neg, c_out, over  output  1 each  ALU flags (combinational).
REQ-013 branch_type  input  3  branch condition select.
REQ-014 branch_taken  output  1  condition met (combinational from flags).

Function
REQ-015 PC SHALL update each rising edge: i_addr <= pc_src ? jump_addr : i_addr + 4, modulo 2^32 (wraps FFFF_FFFC -> 0000_0000).
REQ-016 jump_addr SHALL be loaded unmodified (no alignment masking).
REQ-017 alu_op encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS_B, 110/111 ADD.
REQ-018 ADD: result = A+B, c_out = carry out of bit 31, over = signed overflow.
REQ-019 SUB: result = A + ~B + 1, c_out = carry out of bit 31 (1 = no borrow, i.e. A >= B unsigned), over = signed overflow of A-B.
REQ-020 AND/OR/XOR/PASS_B: c_out = 0, over = 0.
REQ-021 For all ops: zero = (result == 0), neg = result[31].
REQ-022 branch_type encoding SHALL be: 000 none (0), 001 BEQ zero, 010 BNE ~zero, 011 BLT neg^over, 100 BGE ~(neg^over), 101 BLTU ~c_out, 110 BGEU c_out, 111 none (0).
REQ-023 Branch conditions SHALL be valid only when alu_op = SUB; block does not check this.
REQ-024 can_write SHALL be 0 until FILL_CYCLES rising edges have occurred with reset low, then 1 and stay 1 until next reset.
REQ-025 ALU and branch paths SHALL be purely combinational, zero latency; PC has one-cycle latency.

Reset
REQ-026 reset high SHALL immediately force i_addr = RESET_ADDR and can_write = 0 and clear the fill counter, including mid-operation.
REQ-027 First edge after reset release SHALL apply REQ-015 normally (i_addr = RESET_ADDR+4 if pc_src = 0).
REQ-028 Combinational outputs SHALL be unaffected by reset.

Configuration
REQ-029 Macro PC_STALL_EN defined: adds input stall (1 bit); stall = 1 holds i_addr and the fill counter, and pc_src is ignored while stalled.
REQ-030 PC_STALL_EN undefined: no stall port; PC advances every edge.

Structure
REQ-031 Shared package SHALL hold alu_op and branch_type enums, PC_INCREMENT (4) and the default RESET_ADDR.
REQ-032 ALU SHALL be a sub-module, pc_alu_core; PC, fill counter and branch decode stay in the top.

Verification
REQ-033 Reset, release, 4 edges with pc_src = 0 -> i_addr 0,4,8,C,10; can_write 0,0,0,1 after edges 1-3 then 1.
REQ-034 pc_src = 1, jump_addr = 0000_0100 -> next i_addr 0000_0100; next edge with pc_src = 0 -> 0000_0104.
REQ-035 SUB A = 5, B = 5 -> result 0, zero 1, c_out 1; BEQ taken, BNE not, BGEU taken.
REQ-036 SUB A = FFFF_FFFF, B = 1 -> neg 1, over 0, c_out 1; BLT taken, BLTU not taken.
REQ-037 ADD A = 7FFF_FFFF, B = 1 -> result 8000_0000, over 1, neg 1, c_out 0.
REQ-038 Assert reset mid-run at i_addr = 0000_0040 -> i_addr 0 and can_write 0 before the next edge.

Source files
------------

// File: rtl/pc_alu_branch_unit_pkg.sv
// Shared types and constants for the PC / ALU / branch unit.
// Optional PC_STALL_EN build adds a stall input (see pc_alu_branch_unit_if).
package pc_alu_branch_unit_pkg;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_OR     = 3'b011,
    ALU_XOR    = 3'b100,
    ALU_PASS_B = 3'b101,
    ALU_ADD_6  = 3'b110,
    ALU_ADD_7  = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE   = 3'b000,
    BR_EQ     = 3'b001,
    BR_NE     = 3'b010,
    BR_LT     = 3'b011,
    BR_GE     = 3'b100,
    BR_LTU    = 3'b101,
    BR_GEU    = 3'b110,
    BR_NONE_7 = 3'b111
  } branch_type_e;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_e;

  localparam logic [31:0] PC_INCREMENT       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/pc_alu_branch_unit_if.sv
// Bus bundle for pc_alu_branch_unit: PC control, ALU operands/flags, branch select.
// With PC_STALL_EN defined the bundle also carries the stall request.
interface pc_alu_branch_unit_if;
  `ifdef PC_STALL_EN
  logic        stall;
  `endif
  logic        pc_src;
  logic [31:0] jump_addr;
  logic [31:0] i_addr;
  logic        can_write;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  alu_op;
  logic [31:0] result;
  logic        zero;
  logic        neg;
  logic        c_out;
  logic        over;
  logic [2:0]  branch_type;
  logic        branch_taken;

  modport master (
    `ifdef PC_STALL_EN
    output stall,
    `endif
    output pc_src, jump_addr, A, B, alu_op, branch_type,
    input  i_addr, can_write, result, zero, neg, c_out, over, branch_taken
  );

  modport slave (
    `ifdef PC_STALL_EN
    input  stall,
    `endif
    input  pc_src, jump_addr, A, B, alu_op, branch_type,
    output i_addr, can_write, result, zero, neg, c_out, over, branch_taken
  );
endinterface

// File: rtl/pc_alu_core.sv
// Combinational 32-bit ALU; SUB reuses the adder as A + ~B + 1 so c_out means "no borrow".
module pc_alu_core
  import pc_alu_branch_unit_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     alu_op,
  output logic [31:0] result,
  output logic        zero,
  output logic        neg,
  output logic        c_out,
  output logic        over
);

  logic        is_sub;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        sum_over;

  assign is_sub = (alu_op == ALU_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};
  // Overflow when both adder inputs share a sign that the sum does not.
  assign sum_over = (a[31] == b_eff[31]) && (sum[31] != a[31]);

  always_comb begin
    result = sum[31:0];
    c_out  = sum[32];
    over   = sum_over;
    case (alu_op)
      ALU_AND: begin
        result = a & b;
        c_out  = 1'b0;
        over   = 1'b0;
      end
      ALU_OR: begin
        result = a | b;
        c_out  = 1'b0;
        over   = 1'b0;
      end
      ALU_XOR: begin
        result = a ^ b;
        c_out  = 1'b0;
        over   = 1'b0;
      end
      ALU_PASS_B: begin
        result = b;
        c_out  = 1'b0;
        over   = 1'b0;
      end
      default: ;
    endcase
  end

  assign zero = (result == 32'd0);
  assign neg  = result[31];

endmodule

// File: rtl/pc_alu_branch_unit.sv
// PC register with fill-gated can_write, ALU wrapper and branch decode.
// Define PC_STALL_EN to add bus.stall, which freezes the PC and the fill counter.
//
// state   | meaning
// ST_FILL | pipeline filling, down-counter running, can_write = 0
// ST_RUN  | pipeline full, can_write = 1 until next reset
module pc_alu_branch_unit
  import pc_alu_branch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR  = DEFAULT_RESET_ADDR,
  parameter int          FILL_CYCLES = 3
)(
  input logic                 clk,
  input logic                 reset,
  pc_alu_branch_unit_if.slave bus
);

  localparam int CW = (FILL_CYCLES < 2) ? 1 : $clog2(FILL_CYCLES + 1);

  logic          advance;
  logic [31:0]   pc_q;
  fill_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  `ifdef PC_STALL_EN
  assign advance = ~bus.stall;
  `else
  assign advance = 1'b1;
  `endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_ADDR;
    end else if (advance) begin
      pc_q <= bus.pc_src ? bus.jump_addr : pc_q + PC_INCREMENT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      cnt_q   <= CW'(FILL_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The edge that sees a count of one is the last fill edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (advance) begin
      case (state_q)
        ST_FILL: begin
          if (cnt_q <= CW'(1)) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_RUN:  ;
        default: state_d = ST_FILL;
      endcase
    end
  end

  assign bus.i_addr    = pc_q;
  assign bus.can_write = (state_q == ST_RUN);

  pc_alu_core u_alu (
    .a      (bus.A),
    .b      (bus.B),
    .alu_op (alu_op_e'(bus.alu_op)),
    .result (bus.result),
    .zero   (bus.zero),
    .neg    (bus.neg),
    .c_out  (bus.c_out),
    .over   (bus.over)
  );

  // Conditions assume the ALU is performing SUB; nothing enforces that here.
  always_comb begin
    bus.branch_taken = 1'b0;
    case (branch_type_e'(bus.branch_type))
      BR_EQ:   bus.branch_taken = bus.zero;
      BR_NE:   bus.branch_taken = ~bus.zero;
      BR_LT:   bus.branch_taken = bus.neg ^ bus.over;
      BR_GE:   bus.branch_taken = ~(bus.neg ^ bus.over);
      BR_LTU:  bus.branch_taken = ~bus.c_out;
      BR_GEU:  bus.branch_taken = bus.c_out;
      default: bus.branch_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pc_alu_branch_unit.sv
// Scoreboard bench for pc_alu_branch_unit: PC/fill sequence, ALU flags, branches, reset.
module tb_pc_alu_branch_unit;
  import pc_alu_branch_unit_pkg::*;

  localparam int FILL = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_alu_branch_unit_if bus();

  pc_alu_branch_unit #(.RESET_ADDR(32'h0000_0000), .FILL_CYCLES(FILL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        cw;
  } pc_exp_t;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
    logic        t;
  } alu_exp_t;

  pc_exp_t     pc_sb[$];
  alu_exp_t    alu_sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc;
  int          m_edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic alu_exp_t alu_model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic [2:0] bt);
    alu_exp_t e;
    longint   s;
    logic [63:0] u;
    e = '0;
    case (op)
      3'b001: begin
        e.res = a - b;
        e.c   = (a >= b);
        s     = longint'($signed(a)) - longint'($signed(b));
        e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b010: e.res = a & b;
      3'b011: e.res = a | b;
      3'b100: e.res = a ^ b;
      3'b101: e.res = b;
      default: begin
        e.res = a + b;
        u     = {32'd0, a} + {32'd0, b};
        e.c   = u[32];
        s     = longint'($signed(a)) + longint'($signed(b));
        e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    case (bt)
      3'd1:    e.t = e.z;
      3'd2:    e.t = !e.z;
      3'd3:    e.t = e.n ^ e.v;
      3'd4:    e.t = !(e.n ^ e.v);
      3'd5:    e.t = !e.c;
      3'd6:    e.t = e.c;
      default: e.t = 1'b0;
    endcase
    return e;
  endfunction

  task automatic pc_step(input logic src, input logic [31:0] ja);
    pc_exp_t e;
    bus.pc_src    = src;
    bus.jump_addr = ja;
    m_pc    = src ? ja : m_pc + 32'd4;
    m_edges = m_edges + 1;
    e.addr  = m_pc;
    e.cw    = (m_edges >= FILL);
    pc_sb.push_back(e);
    @(posedge clk);
    #1;
    e = pc_sb.pop_front();
    chk("i_addr", bus.i_addr, e.addr);
    chk("can_write", {31'd0, bus.can_write}, {31'd0, e.cw});
  endtask

  task automatic alu_step(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [2:0] bt);
    alu_exp_t e;
    bus.A           = a;
    bus.B           = b;
    bus.alu_op      = op;
    bus.branch_type = bt;
    alu_sb.push_back(alu_model(a, b, op, bt));
    #1;
    e = alu_sb.pop_front();
    chk({tag, "_result"}, bus.result, e.res);
    chk({tag, "_flags"}, {27'd0, bus.zero, bus.neg, bus.c_out, bus.over, bus.branch_taken},
        {27'd0, e.z, e.n, e.c, e.v, e.t});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.pc_src      = 1'b0;
    bus.jump_addr   = 32'd0;
    bus.A           = 32'd0;
    bus.B           = 32'd0;
    bus.alu_op      = 3'd0;
    bus.branch_type = 3'd0;
    `ifdef PC_STALL_EN
    bus.stall       = 1'b0;
    `endif
    m_pc    = 32'd0;
    m_edges = 0;
    #12;
    chk("rst_i_addr", bus.i_addr, 32'd0);
    chk("rst_can_write", {31'd0, bus.can_write}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) pc_step(1'b0, 32'hDEAD_BEEF);
    pc_step(1'b1, 32'h0000_0100);
    pc_step(1'b0, 32'd0);
    pc_step(1'b1, 32'h0000_0123);
    pc_step(1'b0, 32'd0);
    pc_step(1'b1, 32'hFFFF_FFFC);
    pc_step(1'b0, 32'd0);
    pc_step(1'b0, 32'd0);

    alu_step("sub_eq_beq",  32'd5, 32'd5, 3'(ALU_SUB), 3'(BR_EQ));
    alu_step("sub_eq_bne",  32'd5, 32'd5, 3'(ALU_SUB), 3'(BR_NE));
    alu_step("sub_eq_bgeu", 32'd5, 32'd5, 3'(ALU_SUB), 3'(BR_GEU));
    alu_step("sub_m1_blt",  32'hFFFF_FFFF, 32'd1, 3'(ALU_SUB), 3'(BR_LT));
    alu_step("sub_m1_bltu", 32'hFFFF_FFFF, 32'd1, 3'(ALU_SUB), 3'(BR_LTU));
    alu_step("sub_ovf_bge", 32'h8000_0000, 32'd1, 3'(ALU_SUB), 3'(BR_GE));
    alu_step("sub_lt_bltu", 32'd3, 32'd9, 3'(ALU_SUB), 3'(BR_LTU));
    alu_step("add_ovf",     32'h7FFF_FFFF, 32'd1, 3'(ALU_ADD), 3'(BR_NONE));
    alu_step("add_carry",   32'hFFFF_FFFF, 32'd1, 3'(ALU_ADD_6), 3'(BR_EQ));
    alu_step("and",         32'hF0F0_1234, 32'h0FF0_FFFF, 3'(ALU_AND), 3'(BR_NONE_7));
    alu_step("or",          32'hF0F0_0000, 32'h0000_000F, 3'(ALU_OR), 3'(BR_NE));
    alu_step("xor_zero",    32'h1234_5678, 32'h1234_5678, 3'(ALU_XOR), 3'(BR_EQ));
    alu_step("pass_b",      32'h1111_1111, 32'h8000_0001, 3'(ALU_PASS_B), 3'(BR_GEU));
    alu_step("add7",        32'h8000_0000, 32'h8000_0000, 3'(ALU_ADD_7), 3'(BR_GE));
    for (int i = 0; i < 24; i++) begin
      alu_step("rand", $urandom, $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Bring PC to 0x40, then reset in the middle of the cycle.
    pc_step(1'b1, 32'h0000_003C);
    pc_step(1'b0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_i_addr", bus.i_addr, 32'd0);
    chk("midrst_can_write", {31'd0, bus.can_write}, 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_i_addr", bus.i_addr, 32'd0);
    reset   = 1'b0;
    m_pc    = 32'd0;
    m_edges = 0;
    for (int i = 0; i < 4; i++) pc_step(1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
